// File: rtl/imem_loader.sv
// imem_loader
//   Receives a length-prefixed byte stream and writes it into the
//   instruction RAM as 32-bit big-endian words. The CPU is held in reset
//   until a complete program has been written.
//
//   Stream format: count[15:8], count[7:0], then 4*count data bytes.
//   A count of 0 or more than 2048 words is rejected without any write.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle request to begin a load (IDLE/DONE/ERR only)
//   byte_in    serial program byte
//   byte_valid byte_in holds a valid byte
//   byte_ready loader accepts byte_in this cycle
//   we         instruction-RAM write strobe (one cycle per word)
//   waddr      instruction-RAM word address
//   wdata      instruction word to write
//   busy       a load is in progress
//   done       program loaded; held until the next start or rst
//   err        length rejected; held until the next start or rst
//   cpu_rst    holds the CPU in reset unless a valid program is loaded
module imem_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        we,
  output logic [10:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_rst
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [7:0]  cnt_hi;
  logic [10:0] last_idx;
  logic [10:0] idx;
  logic [1:0]  byte_cnt;
  logic [23:0] word_sr;

  logic        accept;
  logic [15:0] count_full;
  logic [15:0] count_m1;
  logic        len_bad;
  logic        can_start;

  assign accept     = byte_valid & byte_ready;
  assign count_full = {cnt_hi, byte_in};
  assign count_m1   = count_full - 16'd1;
  assign len_bad    = (count_full == 16'd0) || (count_full > 16'd2048);
  assign can_start  = (state == IDLE) || (state == DONE) || (state == ERR);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        if (accept) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (accept) state_nxt = len_bad ? ERR : DATA;
      end
      DATA: begin
        if (accept && (byte_cnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = (idx == last_idx) ? DONE : DATA;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are pure state decodes, so an asynchronous reset of
  // the state register forces them to their reset values immediately.
  always_comb begin
    byte_ready = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_rst    = 1'b1;
    case (state)
      LEN_HI, LEN_LO, DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        we   = 1'b1;
        busy = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        cpu_rst = 1'b0;
      end
      ERR: begin
        err = 1'b1;
      end
      default: ;
    endcase
  end

  // Control state, word index, byte counter and the RAM write port.
  // waddr/wdata only change when a word completes, so they hold their
  // last values whenever we is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 11'd0;
      byte_cnt <= 2'd0;
      waddr    <= 11'd0;
      wdata    <= 32'd0;
    end else begin
      state <= state_nxt;
      if (can_start && start) begin
        idx      <= 11'd0;
        byte_cnt <= 2'd0;
      end
      if ((state == DATA) && accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          waddr <= idx;
          wdata <= {word_sr, byte_in};
        end
      end
      if ((state == WRITE) && (idx != last_idx)) begin
        idx <= idx + 11'd1;
      end
    end
  end

  // Length capture and byte assembly; contents are only meaningful once
  // qualified by the control state above, so no reset is needed.
  always_ff @(posedge clk) begin
    if ((state == LEN_HI) && accept) begin
      cnt_hi <= byte_in;
    end
    // N-1 fits in 11 bits for every accepted length (1..2048).
    if ((state == LEN_LO) && accept) begin
      last_idx <= count_m1[10:0];
    end
    if ((state == DATA) && accept) begin
      word_sr <= {word_sr[15:0], byte_in};
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [10:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_rst;

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_rst    (cpu_rst)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: expected RAM writes in order, plus the last write seen.
  logic [10:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [10:0] last_addr;
  logic [31:0] last_data;
  int          wr_seen;
  logic [7:0]  data_bytes [8192];
  bit          tog;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (we) begin
        if (exp_addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_we: got write at %0h expected no write", waddr);
        end else begin
          check("waddr", 32'(waddr), 32'(exp_addr_q.pop_front()));
          check("wdata", wdata, exp_data_q.pop_front());
        end
        check("flags_in_write", 32'({busy, byte_ready, cpu_rst, done, err}), 32'b10100);
        last_addr = waddr;
        last_data = wdata;
        wr_seen++;
      end else begin
        check("waddr_hold", 32'(waddr), 32'(last_addr));
        check("wdata_hold", wdata, last_data);
      end
      check("cpu_rst_vs_done", 32'(cpu_rst), 32'(!done));
      if (byte_ready) check("busy_when_ready", 32'(busy), 32'd1);
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, 32'({we, byte_ready, busy, done, err, cpu_rst}), 32'b000001);
    check({name, "_waddr"}, 32'(waddr), 32'd0);
    check({name, "_wdata"}, wdata, 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // mode 0: continuous valid, 1: valid toggles every cycle, 2: random stalls
  task automatic drive_byte(input logic [7:0] b, input int mode, input bit allow_start, output bit ok);
    bit ok_now;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      tog = ~tog;
      byte_in    = b;
      byte_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 3) != 0);
      start      = allow_start && ($urandom_range(0, 7) == 0);
      ok_now     = byte_valid && byte_ready;
      @(posedge clk);
      if (ok_now) ok = 1'b1;
      #1;
      byte_valid = 1'b0;
      start      = 1'b0;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL byte_timeout: got no accept expected byte %0h taken", b);
    end
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) data_bytes[i] = 8'($urandom);
  endtask

  // Full load transaction. abort_after >= 0 stops after that many data bytes.
  task automatic load(input logic [15:0] n, input int mode, input bit mid_start, input int abort_after);
    bit          ok;
    bit          valid_n;
    int          nb;
    logic [31:0] wd;
    valid_n = (n != 16'd0) && (n <= 16'd2048);
    nb = valid_n ? int'(n) * 4 : 0;
    if (abort_after >= 0) nb = abort_after;
    if (valid_n) begin
      for (int w = 0; w < int'(n); w++) begin
        if ((w + 1) * 4 <= nb) begin
          wd = data_bytes[4*w] * 32'h0100_0000 + data_bytes[4*w+1] * 32'h0001_0000
             + data_bytes[4*w+2] * 32'h0000_0100 + 32'(data_bytes[4*w+3]);
          exp_addr_q.push_back(11'(w));
          exp_data_q.push_back(wd);
        end
      end
    end
    pulse_start();
    drive_byte(n[15:8], mode, mid_start, ok);
    drive_byte(n[7:0], mode, 1'b0, ok);
    for (int i = 0; i < nb; i++) drive_byte(data_bytes[i], mode, mid_start && (i != nb - 1), ok);
    if (abort_after < 0) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done || err) break;
      end
      #1;
      check("end_done", 32'(done), 32'(valid_n));
      check("end_err", 32'(err), 32'(!valid_n));
      check("end_cpu_rst", 32'(cpu_rst), 32'(!valid_n));
      check("end_busy_ready", 32'({busy, byte_ready, we}), 32'd0);
      check("writes_left", 32'(exp_addr_q.size()), 32'd0);
    end
  endtask

  initial begin
    int w0;
    logic [15:0] nr;
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'd0;
    tog = 1'b0;
    last_addr = 11'd0;
    last_data = 32'd0;
    wr_seen = 0;
    #2 check_reset_outputs("reset_state");
    #10 rst = 1'b0;

    // Single word, hand-computed expectation.
    data_bytes[0] = 8'h3C; data_bytes[1] = 8'h01; data_bytes[2] = 8'h00; data_bytes[3] = 8'h01;
    w0 = wr_seen;
    load(16'd1, 0, 1'b0, -1);
    check("one_word_count", 32'(wr_seen - w0), 32'd1);
    check("one_word_addr", 32'(last_addr), 32'd0);
    check("one_word_data", last_data, 32'h3C01_0001);

    // Three words continuous, then the same stream with toggling valid.
    fill_random(12);
    w0 = wr_seen;
    load(16'd3, 0, 1'b0, -1);
    check("three_word_count", 32'(wr_seen - w0), 32'd3);
    check("three_word_last_addr", 32'(last_addr), 32'd2);
    load(16'd3, 1, 1'b0, -1);

    // Rejected lengths, then a normal load.
    w0 = wr_seen;
    load(16'h0000, 0, 1'b0, -1);
    load(16'h0801, 2, 1'b0, -1);
    nr = 16'($urandom_range(2049, 65535));
    load(nr, 2, 1'b0, -1);
    check("err_no_writes", 32'(wr_seen - w0), 32'd0);
    fill_random(20);
    load(16'd5, 2, 1'b1, -1);

    // Reset in the middle of word 5.
    fill_random(32);
    load(16'd8, 0, 1'b0, 22);
    #1 rst = 1'b1;
    last_addr = 11'd0;
    last_data = 32'd0;
    #1 check_reset_outputs("mid_load_reset");
    check("abort_writes_left", 32'(exp_addr_q.size()), 32'd0);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    #1 check_reset_outputs("idle_after_reset");

    // Randomized loads with random stalls and stray start pulses.
    for (int t = 0; t < 4; t++) begin
      nr = 16'($urandom_range(1, 40));
      fill_random(int'(nr) * 4);
      load(nr, int'($urandom_range(0, 2)), 1'b1, -1);
    end

    // Maximum program size.
    fill_random(8192);
    load(16'h0800, 0, 1'b1, -1);
    check("max_last_addr", 32'(last_addr), 32'd2047);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
